// File: rtl/nec_ir_pkg.sv
// Shared types and timing constants for the NEC IR decoder.
// Window limits are kept in microseconds and turned into clock cycles
// at elaboration with us2cyc().
package nec_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_STOP,
    CHECK
  } state_t;

  localparam longint LEAD_MARK_MIN_US  = 8500;
  localparam longint LEAD_MARK_MAX_US  = 9500;
  localparam longint LEAD_DATA_MIN_US  = 4000;
  localparam longint LEAD_DATA_MAX_US  = 5000;
  localparam longint LEAD_RPT_MIN_US   = 2000;
  localparam longint LEAD_RPT_MAX_US   = 2500;
  localparam longint BIT_MARK_MIN_US   = 400;
  localparam longint BIT_MARK_MAX_US   = 750;
  localparam longint BIT_ZERO_MIN_US   = 400;
  localparam longint BIT_ZERO_MAX_US   = 750;
  localparam longint BIT_ONE_MIN_US    = 1400;
  localparam longint BIT_ONE_MAX_US    = 1900;
  localparam longint TIMEOUT_US        = 12000;
  localparam longint REPEAT_WIN_US     = 120000;

  // Microseconds to whole clock cycles; 64-bit so large clocks do not overflow.
  function automatic longint us2cyc(input longint clk_hz, input longint us);
    return (clk_hz * us) / 1000000;
  endfunction

endpackage

// File: rtl/nec_ir_glitch_filter.sv
// Stable-count deglitcher: the output level follows the input only after
// the input has differed from it for G consecutive cycles. Idles high.
module ir_glitch_filter #(
  parameter int G = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(G + 1);

  logic [CW-1:0] cnt;

  // Count disagreement cycles; flip the level and strobe once G is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (din == level) begin
        cnt <= '0;
      end else if (cnt == CW'(G - 1)) begin
        level <= din;
        rise  <= din;
        fall  <= ~din;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR remote decoder: synchronise + deglitch the demodulator output,
// measure mark/space widths, decode 32-bit frames and repeat codes.
module nec_ir_decoder
  import nec_ir_pkg::*;
#(
  parameter int          CLK_HZ      = 50_000_000,
  parameter int          ADDR_CHECK  = 1,
  parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
  parameter int          GLITCH_US   = 10,
  parameter int          REPEAT_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_rxd,
  output logic [7:0]  code,
  output logic [15:0] addr,
  output logic        valid,
  output logic        rpt,
  output logic        err,
  output logic        busy
);

  localparam longint G_RAW  = us2cyc(CLK_HZ, GLITCH_US);
  localparam int     G      = (G_RAW < 1) ? 1 : int'(G_RAW);
  localparam longint TO_CYC = us2cyc(CLK_HZ, TIMEOUT_US);
  localparam longint RW_CYC = us2cyc(CLK_HZ, REPEAT_WIN_US);
  localparam int     WW     = $clog2(TO_CYC) + 1;
  localparam int     RW     = $clog2(RW_CYC) + 1;

  typedef logic [WW-1:0] width_t;

  localparam width_t T_TO    = width_t'(TO_CYC);
  localparam width_t LM_MIN  = width_t'(us2cyc(CLK_HZ, LEAD_MARK_MIN_US));
  localparam width_t LM_MAX  = width_t'(us2cyc(CLK_HZ, LEAD_MARK_MAX_US));
  localparam width_t LD_MIN  = width_t'(us2cyc(CLK_HZ, LEAD_DATA_MIN_US));
  localparam width_t LD_MAX  = width_t'(us2cyc(CLK_HZ, LEAD_DATA_MAX_US));
  localparam width_t LR_MIN  = width_t'(us2cyc(CLK_HZ, LEAD_RPT_MIN_US));
  localparam width_t LR_MAX  = width_t'(us2cyc(CLK_HZ, LEAD_RPT_MAX_US));
  localparam width_t BM_MIN  = width_t'(us2cyc(CLK_HZ, BIT_MARK_MIN_US));
  localparam width_t BM_MAX  = width_t'(us2cyc(CLK_HZ, BIT_MARK_MAX_US));
  localparam width_t B0_MIN  = width_t'(us2cyc(CLK_HZ, BIT_ZERO_MIN_US));
  localparam width_t B0_MAX  = width_t'(us2cyc(CLK_HZ, BIT_ZERO_MAX_US));
  localparam width_t B1_MIN  = width_t'(us2cyc(CLK_HZ, BIT_ONE_MIN_US));
  localparam width_t B1_MAX  = width_t'(us2cyc(CLK_HZ, BIT_ONE_MAX_US));
  localparam logic [RW-1:0] T_RPT = RW'(RW_CYC);

  function automatic logic in_win(input width_t w, input width_t lo, input width_t hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic          rxd_p0, rxd_p1;
  logic          lvl, rise_e, fall_e;
  logic          edge_e, mark_start, mark_end;
  width_t        width;
  state_t        state;
  logic [4:0]    bit_cnt;
  logic [31:0]   shreg;
  logic          rpt_flag;
  logic [RW-1:0] rpt_cnt;

  // Two-flop synchroniser, idle-high so leaving reset creates no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= ir_rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  ir_glitch_filter #(.G(G)) u_filter (
    .clk   (clk),
    .rst   (rst),
    .din   (rxd_p1),
    .level (lvl),
    .rise  (rise_e),
    .fall  (fall_e)
  );

  // Line is active-low: a falling filtered edge opens a mark, a rising one closes it
  assign edge_e     = rise_e | fall_e;
  assign mark_start = edge_e & ~lvl;
  assign mark_end   = edge_e & lvl;
  assign busy       = (state != IDLE);

  // Width counter: value on an edge cycle is the length of the phase just ended
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width <= '0;
    end else if (edge_e) begin
      width <= width_t'(1);
    end else if (width != T_TO) begin
      width <= width + 1'b1;
    end
  end

  // Frame decoder: advance on filtered edges, judging each completed width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      code    <= '0;
      addr    <= '0;
      valid   <= 1'b0;
      rpt     <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      rpt   <= 1'b0;
      err   <= 1'b0;
      if (state != IDLE && width == T_TO) begin
        err   <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (mark_start) state <= LEAD_MARK;
          end
          LEAD_MARK: begin
            if (mark_end) begin
              if (in_win(width, LM_MIN, LM_MAX)) begin
                state <= LEAD_SPACE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
          LEAD_SPACE: begin
            if (mark_start) begin
              if (in_win(width, LD_MIN, LD_MAX)) begin
                bit_cnt <= '0;
                state   <= BIT_MARK;
              end else if (REPEAT_EN != 0 && in_win(width, LR_MIN, LR_MAX)) begin
                state <= RPT_STOP;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
          BIT_MARK: begin
            if (mark_end) begin
              if (in_win(width, BM_MIN, BM_MAX)) begin
                state <= BIT_SPACE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
          BIT_SPACE: begin
            if (mark_start) begin
              if (in_win(width, B0_MIN, B0_MAX) || in_win(width, B1_MIN, B1_MAX)) begin
                // LSB-first: the first bit on air ends up in shreg[0]
                shreg   <= {in_win(width, B1_MIN, B1_MAX), shreg[31:1]};
                bit_cnt <= bit_cnt + 1'b1;
                state   <= (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
          STOP_MARK: begin
            if (mark_end) begin
              if (in_win(width, BM_MIN, BM_MAX)) begin
                state <= CHECK;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
          RPT_STOP: begin
            if (mark_end) begin
              if (in_win(width, BM_MIN, BM_MAX) && rpt_flag) rpt <= 1'b1;
              else                                           err <= 1'b1;
              state <= IDLE;
            end
          end
          CHECK: begin
            if (shreg[31:24] == ~shreg[23:16] &&
                (ADDR_CHECK == 0 || shreg[15:0] == CUSTOM_CODE)) begin
              code  <= shreg[23:16];
              addr  <= shreg[15:0];
              valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Repeat window: armed by each accepted frame or repeat, dropped on error or expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_flag <= 1'b0;
      rpt_cnt  <= '0;
    end else if (err) begin
      rpt_flag <= 1'b0;
    end else if (valid || rpt) begin
      rpt_flag <= 1'b1;
      rpt_cnt  <= '0;
    end else if (rpt_flag) begin
      if (rpt_cnt == T_RPT) rpt_flag <= 1'b0;
      else                  rpt_cnt  <= rpt_cnt + 1'b1;
    end
  end

endmodule
